// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32M sequential multiplier: operation select and FSM states.
`default_nettype none

package riscv_pkg;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_SIGN = 2'b10,
      ST_DONE = 2'b11
   } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/multiplicador_seq_somador.sv
// SIZE-bit ripple adder with carry-in and carry-out used for partial-product accumulation.
`default_nettype none

module somador #(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            cin,
   output logic [SIZE-1:0] sum,
   output logic            cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/multiplicador_seq.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU; one multiplier bit per cycle.
`default_nettype none

module multiplicador_seq
   import riscv_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] result
);

   localparam int CW = $clog2(SIZE) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(SIZE - 1);

   mul_state_t state, state_next;

   logic [1:0]        op_q;
   logic [SIZE-1:0]   mcand;
   logic [SIZE-1:0]   acc_hi;
   logic [SIZE-1:0]   acc_lo;
   logic [CW-1:0]     count;
   logic              neg;

   logic              accept;
   logic              a_signed;
   logic              b_signed;
   logic [SIZE-1:0]   mag_a;
   logic [SIZE-1:0]   mag_b;
   logic              neg_in;
   logic [SIZE-1:0]   addend;
   logic [SIZE-1:0]   sum;
   logic              carry;
   logic [2*SIZE-1:0] product;
   logic [2*SIZE-1:0] product_signed;

   assign accept   = start && (state == ST_IDLE || state == ST_DONE);
   assign a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   assign b_signed = (op == MUL_OP_MULH);
   assign mag_a    = (a_signed && a[SIZE-1]) ? -a : a;
   assign mag_b    = (b_signed && b[SIZE-1]) ? -b : b;
   assign neg_in   = (a_signed && a[SIZE-1]) ^ (b_signed && b[SIZE-1]);

   assign addend = acc_lo[0] ? mcand : '0;

   somador #(.SIZE(SIZE)) u_somador (
      .a    (acc_hi),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

   assign product        = {acc_hi, acc_lo};
   assign product_signed = neg ? -product : product;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_CALC;
         ST_CALC: if (count == LAST_ITER) state_next = ST_SIGN;
         ST_SIGN: state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_CALC : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= MUL_OP_MUL;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         count  <= '0;
         neg    <= 1'b0;
         result <= '0;
      end else begin
         if (accept) begin
            op_q   <= op;
            mcand  <= mag_a;
            acc_hi <= '0;
            acc_lo <= mag_b;
            count  <= '0;
            neg    <= neg_in;
         end else if (state == ST_CALC) begin
            // The adder carry becomes the new MSB as the whole accumulator shifts right.
            acc_hi <= {carry, sum[SIZE-1:1]};
            acc_lo <= {sum[0], acc_lo[SIZE-1:1]};
            count  <= count + CW'(1);
         end
         if (state == ST_SIGN) begin
            result <= (op_q == MUL_OP_MUL) ? product_signed[SIZE-1:0]
                                           : product_signed[2*SIZE-1:SIZE];
         end
      end
   end

   assign busy = (state == ST_CALC) || (state == ST_SIGN);
   assign done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_multiplicador_seq.sv
// Directed test of multiplicador_seq: vector table plus back-to-back and async-reset sequences.
`default_nettype none

module tb_multiplicador_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   multiplicador_seq #(.SIZE(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Start one op at the current negedge, then check latency, busy window, result and pulse width.
   task automatic run_op(input int idx, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      int lat;
      int busy_bad;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~x; b = ~y;
      lat = 1; busy_bad = 0;
      while (!done && lat < 100) begin
         if (!busy) busy_bad++;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd34);
      chk($sformatf("v%0d_busy_window", idx), 64'(busy_bad), 64'd0);
      chk($sformatf("v%0d_result", idx), {32'd0, result}, {32'd0, exp});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", idx), {62'd0, busy, done}, 64'd0);
      chk($sformatf("v%0d_result_held", idx), {32'd0, result}, {32'd0, exp});
   endtask

   initial begin
      int lat;

      vecs[0]  = '{2'b00, 32'd7,        32'd6,        32'h0000002A};
      vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[3]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[4]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
      vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
      vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000};
      vecs[7]  = '{2'b10, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
      vecs[8]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF};
      vecs[9]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1};
      vecs[10] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
      vecs[11] = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #1;
      chk("reset_state", {31'd0, busy, done, result}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {31'd0, busy, done, result}, 64'd0);

      for (int i = 0; i < 12; i++)
         run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Back-to-back: second start issued in the done cycle of the first.
      op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_first_latency", 64'(lat), 64'd34);
      chk("b2b_first_result", {32'd0, result}, 64'd15);
      a = 32'd4; b = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == 10) begin
            start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd9;
         end else begin
            start = 1'b0;
         end
         if (lat == 20) chk("b2b_result_stable_while_busy", {32'd0, result}, 64'd15);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("b2b_second_latency", 64'(lat), 64'd34);
      chk("b2b_second_result", {32'd0, result}, 64'h10);
      @(negedge clk);
      chk("b2b_back_to_idle", {62'd0, busy, done}, 64'd0);

      // Async reset in the middle of an operation.
      op = 2'b00; a = 32'd100; b = 32'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy_before_reset", {63'd0, busy}, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("abort_async_clear", {31'd0, busy, done, result}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_no_done", {62'd0, busy, done}, 64'd0);
      run_op(99, 2'b00, 32'd100, 32'd100, 32'h00002710);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits downstream of the ALU operand muxes, beside the ALU in the execute stage. Each cycle it feeds one partial-product accumulation through the datapath adder (SOMADOR). The control unit stalls the pipeline while busy is high.

Parameters:
SIZE, 32, operand and result width in bits; must be at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a multiply; sampled only when busy=0.
op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (equals funct3[1:0]).
a  input  SIZE  multiplicand (rs1).
b  input  SIZE  multiplier (rs2).
busy  output  1  operation in progress; new start ignored.
done  output  1  one-cycle pulse; result valid.
result  output  SIZE  selected product half; held until the next accepted start.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers cleared.
  - An operation in flight is aborted, with no done pulse.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, or DONE, with start=1:
  - Latch op.
  - Magnitude mcand = |a| if op is MULH or MULHSU, else a.
  - Magnitude mplier = |b| if op is MULH, else b.
  - Magnitudes are unsigned SIZE bits; |-2^(SIZE-1)| = 2^(SIZE-1).
  - neg = XOR of the operand signs for the signed operands only.
  - acc_hi=0, acc_lo=mplier, count=0; go to CALC.
- start=1 in CALC or SIGN: ignored; latched operands unchanged.
- CALC, one iteration per cycle:
  - sum = acc_hi + (acc_lo[0] ? mcand : 0), giving SIZE bits plus carry via SOMADOR, Cin=0.
  - {acc_hi, acc_lo} <= {carry, sum, acc_lo} >> 1.
  - count++; after SIZE iterations go to SIGN.
- SIGN (one cycle): if neg, the 2*SIZE-bit product = ~product + 1, else unchanged. Go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - result = product[SIZE-1:0] for MUL, product[2*SIZE-1:SIZE] otherwise.
  - Without start, go to IDLE the next cycle.
  - With start, accept it (back-to-back).
- busy=1 in CALC and SIGN, 0 in IDLE and DONE.
- Latency: start sampled in cycle 0 -> busy in cycles 1..SIZE+1 -> done in cycle SIZE+2.
- result register is written only on entry to DONE; stable at all other times.
- Operand changes after the start cycle have no effect.
- Products are exact in 2*SIZE bits; no overflow flag.

Decomposition:
- Shared package (riscv_pkg):
  - op encoding constants MUL_OP_MUL/MULH/MULHSU/MULHU.
  - state encoding for IDLE/CALC/SIGN/DONE.
- One sub-module: SOMADOR #(SIZE), instantiated once for the accumulate add.
  - Its carry-out is required and must be driven.
- Two's-complement negation of operands and product stays inline.
- Counter width is $clog2(SIZE)+1.

Test Plan:
- MUL a=7, b=6, start in cycle 0 -> busy cycles 1-33, done pulse only in cycle 34, result=0x0000002A.
- MUL and MULH, a=b=0xFFFFFFFF -> MUL result=0x00000001; MULH result=0x00000000.
- MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0x00000002 -> result=0xFFFFFFFF.
- MULH a=b=0x80000000 -> result=0x40000000; MUL same operands -> result=0x00000000.
- MUL 3*5 completes, then start re-asserted in its done cycle with MUL 4*4 -> second done 34 cycles later, result=0x10; a start pulse (9*9) in cycle 10 of the second operation is ignored.
- MUL 100*100 started, reset asserted mid-cycle 10 (async) -> busy=0, done=0, result=0 immediately; after release, MUL 100*100 -> result=0x00002710.
